voxel_scene_gen: RTL and testbench
==================================

# voxel_scene_gen

Parametrised procedural scene generator for cubic voxel volumes of 2^GRID_LOG2 per side. It fills the volume in one raster pass, writing every voxel exactly once. Each voxel gets the payload of the highest-priority configured primitive (sphere, axis-aligned box or Y-plane) that covers it, or the clear value if none does. It sits between the host config bus and the voxel memory write port, and honours write backpressure from the memory arbiter.

## Interface
- GRID_LOG2, 6: log2 of the grid side; coordinates are GRID_LOG2 bits wide.
- NUM_PRIMS, 4: number of primitive slots (1..16).
- DATA_W, 64: voxel payload width.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write strobe for primitive slot cfg_idx; ignored while busy
- cfg_idx  in  4  slot index; writes to indices >= NUM_PRIMS are ignored
- cfg_kind  in  2  primitive kind: 0 none, 1 sphere, 2 box, 3 Y-plane
- cfg_cx, cfg_cy, cfg_cz  in  GRID_LOG2 each  primitive centre
- cfg_r  in  GRID_LOG2  sphere radius or box half-extent
- cfg_data  in  DATA_W  payload written for voxels covered by this slot
- clear_data  in  DATA_W  payload for uncovered voxels; sampled at start
- start  in  1  one-cycle pulse; ignored while busy
- abort  in  1  stops the scan immediately
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse on normal completion
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts the write
- wr_addr  out  3*GRID_LOG2  address {x,y,z}
- wr_data  out  DATA_W  payload

## Operation
- States:
  - IDLE: start moves the FSM to SCAN.
  - SCAN: the counter reaching the last voxel moves the FSM to DRAIN.
  - DRAIN: acceptance of the last write moves the FSM to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
  - abort from any state returns the FSM to IDLE.
- Scan order: z is the fastest index, x the slowest; the counter wraps at 2^GRID_LOG2 - 1 per axis.
- Per-slot differences: dx = x - cx as a signed value of GRID_LOG2+1 bits; dy and dz likewise.
- Sphere hit: dx²+dy²+dz² <= r², computed in 2*GRID_LOG2+4 bits with no truncation.
- Box hit: |dx|<=r and |dy|<=r and |dz|<=r.
- Plane hit: y == cy. cx, cz and r are ignored.
- Kind 0 never hits.
- Priority: the highest slot index that hits wins; its cfg_data is written. If no slot hits, clear_data is written.
- The slot table and clear_data are frozen (snapshotted) at start.
- Reset clears every slot's kind to 0.

## Timing
- Reset values: busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, state=IDLE.
- The pipeline has 2 stages: stage 1 computes differences and squares, stage 2 does compare, priority select and the output register.
- start is sampled at cycle T. busy=1 at T+1. The first wr_valid (addr 0) appears at T+3.
- With wr_ready held high, throughput is 1 write per cycle. The last write is accepted at T+2+2^(3*GRID_LOG2). done pulses on the next cycle, and busy falls in that same cycle.
- Backpressure: while wr_valid=1 and wr_ready=0, wr_addr and wr_data are held stable, the whole pipeline stalls, and no voxel is skipped or duplicated.
- abort has priority over start and over the handshake. On the next cycle wr_valid=0 and busy=0, with no done pulse. A start in the cycle after abort is accepted normally.
- A start pulse while busy=1 has no effect.
- A cfg_we while busy=1 does not alter the running scan.

## Configuration
- VOXEL_GEN_BOX_EN:
  - Defined: kind 2 is evaluated as an axis-aligned box.
  - Undefined: the box comparators are not synthesised, and kind 2 behaves as kind 0.

## Test plan
All scenarios use GRID_LOG2=3 (512 voxels).
- Empty table, clear_data=0xAA, wr_ready=1 → exactly 512 writes, addresses 0..511 in order, all data 0xAA, done at T+515.
- Slot 0 sphere at (4,4,4) with r=2 → exactly 33 voxels carry slot 0's cfg_data, e.g. (4,4,6) covered and (4,5,6) not.
- Slot 0 plane cy=1 plus slot 1 box at (1,1,1) with r=1 → the box's 9 voxels in y=1 take slot 1 data; the other 55 plane voxels take slot 0 data. Without VOXEL_GEN_BOX_EN, all 64 take slot 0 data.
- Random wr_ready at 30% duty → the 512 writes arrive unique and in order, addr/data are stable during each stall, and done follows the final accept by 1 cycle.
- abort at write #100 → wr_valid=0 and busy=0 next cycle with no done. A restart then yields a full 512-write pass.
- cfg_we and a second start mid-scan → output is identical to the pre-start snapshot and there is exactly one done pulse.

Source files
------------

// File: rtl/voxel_scene_gen.sv
// Procedural voxel scene generator: raster-scans a 2^GRID_LOG2 cube and writes each voxel's winning primitive payload.
// Optional feature macro: VOXEL_GEN_BOX_EN enables axis-aligned box primitives (kind 2).
module voxel_scene_gen #(
    parameter int GRID_LOG2 = 6,
    parameter int NUM_PRIMS = 4,
    parameter int DATA_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_idx,
    input  logic [1:0]             cfg_kind,
    input  logic [GRID_LOG2-1:0]   cfg_cx,
    input  logic [GRID_LOG2-1:0]   cfg_cy,
    input  logic [GRID_LOG2-1:0]   cfg_cz,
    input  logic [GRID_LOG2-1:0]   cfg_r,
    input  logic [DATA_W-1:0]      cfg_data,
    input  logic [DATA_W-1:0]      clear_data,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [3*GRID_LOG2-1:0] wr_addr,
    output logic [DATA_W-1:0]      wr_data
);
    localparam int G      = GRID_LOG2;
    localparam int AW     = 3 * GRID_LOG2;
    localparam int SW     = 2 * GRID_LOG2 + 4;
    localparam int DIFF_W = GRID_LOG2 + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_t;

    state_t            state_r;
    logic [AW-1:0]     cnt_r;
    logic [1:0]        kind_r      [NUM_PRIMS];
    logic [G-1:0]      cx_r        [NUM_PRIMS];
    logic [G-1:0]      cy_r        [NUM_PRIMS];
    logic [G-1:0]      cz_r        [NUM_PRIMS];
    logic [G-1:0]      r_r         [NUM_PRIMS];
    logic [DATA_W-1:0] data_r      [NUM_PRIMS];
    logic [1:0]        snap_kind_r [NUM_PRIMS];
    logic [G-1:0]      snap_cx_r   [NUM_PRIMS];
    logic [G-1:0]      snap_cy_r   [NUM_PRIMS];
    logic [G-1:0]      snap_cz_r   [NUM_PRIMS];
    logic [G-1:0]      snap_r_r    [NUM_PRIMS];
    logic [DATA_W-1:0] snap_data_r [NUM_PRIMS];
    logic [DATA_W-1:0] snap_clear_r;

    logic [DIFF_W-1:0] dx_s [NUM_PRIMS];
    logic [DIFF_W-1:0] dy_s [NUM_PRIMS];
    logic [DIFF_W-1:0] dz_s [NUM_PRIMS];
    logic [DIFF_W-1:0] adx_s [NUM_PRIMS];
    logic [DIFF_W-1:0] ady_s [NUM_PRIMS];
    logic [DIFF_W-1:0] adz_s [NUM_PRIMS];
    logic [SW-1:0]     sq_s [NUM_PRIMS];
    logic [SW-1:0]     r_sq_s [NUM_PRIMS];
    logic [SW-1:0]     s1_sq_r [NUM_PRIMS];
`ifdef VOXEL_GEN_BOX_EN
    logic [DIFF_W-1:0] s1_adx_r [NUM_PRIMS];
    logic [DIFF_W-1:0] s1_ady_r [NUM_PRIMS];
    logic [DIFF_W-1:0] s1_adz_r [NUM_PRIMS];
`endif
    logic              s1_valid_r;
    logic [AW-1:0]     s1_addr_r;
    logic [NUM_PRIMS-1:0] hit_s;
    logic [DATA_W-1:0] sel_data_s;

    logic en_s;
    logic issue_s;
    logic start_acc_s;
    logic [G-1:0] cur_x_s, cur_y_s, cur_z_s, s1_y_s;

    // Whole pipeline advances only when the output register is free or being accepted.
    assign en_s        = !(wr_valid && !wr_ready);
    assign issue_s     = (state_r == ST_SCAN) && en_s;
    assign start_acc_s = (state_r == ST_IDLE) && start && !abort;
    assign cur_x_s     = cnt_r[AW-1 -: G];
    assign cur_y_s     = cnt_r[2*G-1 -: G];
    assign cur_z_s     = cnt_r[G-1:0];
    assign s1_y_s      = s1_addr_r[2*G-1 -: G];

    // Control FSM with registered busy/done; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {AW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            cnt_r   <= {AW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_SCAN;
                        busy    <= 1'b1;
                        cnt_r   <= {AW{1'b0}};
                    end
                end
                ST_SCAN: begin
                    if (en_s) begin
                        cnt_r <= cnt_r + AW'(1);
                        if (cnt_r == {AW{1'b1}}) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wr_valid && wr_ready && !s1_valid_r) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Host-visible slot table; writes are dropped while a scan is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRIMS; i++) begin
                kind_r[i] <= 2'd0;
                cx_r[i]   <= {G{1'b0}};
                cy_r[i]   <= {G{1'b0}};
                cz_r[i]   <= {G{1'b0}};
                r_r[i]    <= {G{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (cfg_we && !busy) begin
            for (int i = 0; i < NUM_PRIMS; i++) begin
                if (cfg_idx == 4'(i)) begin
                    kind_r[i] <= cfg_kind;
                    cx_r[i]   <= cfg_cx;
                    cy_r[i]   <= cfg_cy;
                    cz_r[i]   <= cfg_cz;
                    r_r[i]    <= cfg_r;
                    data_r[i] <= cfg_data;
                end
            end
        end
    end

    // Snapshot of the table and clear value taken when a scan is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_clear_r <= {DATA_W{1'b0}};
            for (int i = 0; i < NUM_PRIMS; i++) begin
                snap_kind_r[i] <= 2'd0;
                snap_cx_r[i]   <= {G{1'b0}};
                snap_cy_r[i]   <= {G{1'b0}};
                snap_cz_r[i]   <= {G{1'b0}};
                snap_r_r[i]    <= {G{1'b0}};
                snap_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (start_acc_s) begin
            snap_clear_r <= clear_data;
            snap_kind_r  <= kind_r;
            snap_cx_r    <= cx_r;
            snap_cy_r    <= cy_r;
            snap_cz_r    <= cz_r;
            snap_r_r     <= r_r;
            snap_data_r  <= data_r;
        end
    end

    // Stage 1 combinational: two's-complement differences, magnitudes and full-width squared distance.
    always_comb begin
        for (int i = 0; i < NUM_PRIMS; i++) begin
            dx_s[i]  = {1'b0, cur_x_s} - {1'b0, snap_cx_r[i]};
            dy_s[i]  = {1'b0, cur_y_s} - {1'b0, snap_cy_r[i]};
            dz_s[i]  = {1'b0, cur_z_s} - {1'b0, snap_cz_r[i]};
            adx_s[i] = dx_s[i][G] ? (~dx_s[i] + DIFF_W'(1)) : dx_s[i];
            ady_s[i] = dy_s[i][G] ? (~dy_s[i] + DIFF_W'(1)) : dy_s[i];
            adz_s[i] = dz_s[i][G] ? (~dz_s[i] + DIFF_W'(1)) : dz_s[i];
            sq_s[i]  = SW'(adx_s[i]) * SW'(adx_s[i]) + SW'(ady_s[i]) * SW'(ady_s[i])
                     + SW'(adz_s[i]) * SW'(adz_s[i]);
        end
    end

    // Stage 2 combinational: per-slot hit test and highest-index priority select.
    always_comb begin
        hit_s      = {NUM_PRIMS{1'b0}};
        sel_data_s = snap_clear_r;
        for (int i = 0; i < NUM_PRIMS; i++) begin
            r_sq_s[i] = SW'(snap_r_r[i]) * SW'(snap_r_r[i]);
            case (snap_kind_r[i])
                2'd1: hit_s[i] = (s1_sq_r[i] <= r_sq_s[i]);
`ifdef VOXEL_GEN_BOX_EN
                2'd2: hit_s[i] = (s1_adx_r[i] <= {1'b0, snap_r_r[i]}) &&
                                 (s1_ady_r[i] <= {1'b0, snap_r_r[i]}) &&
                                 (s1_adz_r[i] <= {1'b0, snap_r_r[i]});
`else
                2'd2: hit_s[i] = 1'b0;
`endif
                2'd3: hit_s[i] = (s1_y_s == snap_cy_r[i]);
                default: hit_s[i] = 1'b0;
            endcase
            if (hit_s[i]) begin
                sel_data_s = snap_data_r[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Pipeline registers (stage 1 and output stage), frozen as a whole under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= {AW{1'b0}};
            wr_valid   <= 1'b0;
            wr_addr    <= {AW{1'b0}};
            wr_data    <= {DATA_W{1'b0}};
            for (int i = 0; i < NUM_PRIMS; i++) begin
                s1_sq_r[i] <= {SW{1'b0}};
`ifdef VOXEL_GEN_BOX_EN
                s1_adx_r[i] <= {DIFF_W{1'b0}};
                s1_ady_r[i] <= {DIFF_W{1'b0}};
                s1_adz_r[i] <= {DIFF_W{1'b0}};
`endif
            end
        end else if (abort) begin
            s1_valid_r <= 1'b0;
            wr_valid   <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= issue_s;
            s1_addr_r  <= cnt_r;
            s1_sq_r    <= sq_s;
`ifdef VOXEL_GEN_BOX_EN
            s1_adx_r   <= adx_s;
            s1_ady_r   <= ady_s;
            s1_adz_r   <= adz_s;
`endif
            wr_valid   <= s1_valid_r;
            if (s1_valid_r) begin
                wr_addr <= s1_addr_r;
                wr_data <= sel_data_s;
            end
        end
    end
endmodule

// File: tb/tb_voxel_scene_gen.sv
// Self-checking bench for voxel_scene_gen (8x8x8 grid) against a plain-arithmetic scene model.
module tb_voxel_scene_gen;
    localparam int G  = 3;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int NV = 512;

    logic          clk, rst_n, cfg_we, start, abort, busy, done, wr_valid, wr_ready;
    logic [3:0]    cfg_idx;
    logic [1:0]    cfg_kind;
    logic [G-1:0]  cfg_cx, cfg_cy, cfg_cz, cfg_r;
    logic [DW-1:0] cfg_data, clear_data, wr_data;
    logic [3*G-1:0] wr_addr;

    voxel_scene_gen #(.GRID_LOG2(G), .NUM_PRIMS(NP), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind),
        .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_cz(cfg_cz), .cfg_r(cfg_r), .cfg_data(cfg_data),
        .clear_data(clear_data), .start(start), .abort(abort), .busy(busy), .done(done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference scene description (what the host configured)
    int            m_kind [NP];
    int            m_cx [NP], m_cy [NP], m_cz [NP], m_r [NP];
    logic [DW-1:0] m_data [NP];
    logic [DW-1:0] m_clear;

    // Observations of one pass
    logic [3*G-1:0] got_addr [NV];
    logic [DW-1:0]  got_data [NV];
    int n_wr, first_valid, last_acc, done_cyc, busy_t1, busy_at_done, stab_err, done_cnt;
    int post_abort_valid, post_abort_busy;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DW-1:0] model_voxel(input int x, input int y, input int z);
        logic [DW-1:0] res;
        int dx, dy, dz;
        bit hit;
        res = m_clear;
        for (int i = 0; i < NP; i++) begin
            dx = x - m_cx[i];
            dy = y - m_cy[i];
            dz = z - m_cz[i];
            hit = 1'b0;
            case (m_kind[i])
                1: hit = (dx * dx + dy * dy + dz * dz) <= (m_r[i] * m_r[i]);
`ifdef VOXEL_GEN_BOX_EN
                2: hit = (iabs(dx) <= m_r[i]) && (iabs(dy) <= m_r[i]) && (iabs(dz) <= m_r[i]);
`endif
                3: hit = (y == m_cy[i]);
                default: hit = 1'b0;
            endcase
            if (hit) res = m_data[i];
        end
        return res;
    endfunction

    // Number of observed writes (first n) whose address or data differ from the model
    function automatic int count_bad(input int n, output int first);
        int bad;
        bad = 0;
        first = -1;
        for (int k = 0; k < n && k < NV; k++) begin
            if (got_addr[k] !== 9'(k) || got_data[k] !== model_voxel(k / 64, (k / 8) % 8, k % 8)) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic cfg_write(input int idx, input int kind, input int cx, input int cy, input int cz,
                             input int r, input logic [DW-1:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_kind = 2'(kind);
        cfg_cx = 3'(cx); cfg_cy = 3'(cy); cfg_cz = 3'(cz); cfg_r = 3'(r); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < NP) begin
            m_kind[idx] = kind; m_cx[idx] = cx; m_cy[idx] = cy; m_cz[idx] = cz;
            m_r[idx] = r; m_data[idx] = data;
        end
    endtask

    task automatic random_table();
        for (int i = 0; i < NP; i++)
            cfg_write(i, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), {$urandom, $urandom});
        m_clear = {$urandom, $urandom};
        clear_data = m_clear;
    endtask

    // Launch one pass and record everything the DUT emits; cycle i is i clocks after the start edge.
    task automatic run_pass(input int ready_pct, input int abort_at, input int poke_at);
        bit hold;
        logic [3*G-1:0] h_addr;
        logic [DW-1:0]  h_data;
        hold = 1'b0; h_addr = '0; h_data = '0;
        n_wr = 0; first_valid = -1; last_acc = -1; done_cyc = -1; busy_at_done = -1;
        stab_err = 0; done_cnt = 0; post_abort_valid = -1; post_abort_busy = -1;
        @(negedge clk);
        wr_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_t1 = int'(busy);
        for (int i = 1; i < 6000; i++) begin
            start = 1'b0;
            cfg_we = 1'b0;
            if (hold) begin
                if (!wr_valid || wr_addr !== h_addr || wr_data !== h_data) stab_err++;
                hold = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = i;
                    busy_at_done = int'(busy);
                end
            end
            if (wr_valid && first_valid < 0) first_valid = i;
            if (i == poke_at) begin
                cfg_we = 1'b1; cfg_idx = 4'd0; cfg_kind = 2'd3; cfg_cy = 3'($urandom_range(0, 7));
                cfg_data = {$urandom, $urandom};
                clear_data = {$urandom, $urandom};
                start = 1'b1;
            end
            if (abort_at > 0 && n_wr == abort_at) begin
                wr_ready = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                post_abort_valid = int'(wr_valid);
                post_abort_busy = int'(busy);
                for (int j = 0; j < 20; j++) begin
                    if (done) done_cnt++;
                    @(negedge clk);
                end
                break;
            end
            wr_ready = ($urandom_range(0, 99) < ready_pct);
            if (wr_valid) begin
                if (wr_ready) begin
                    if (n_wr < NV) begin
                        got_addr[n_wr] = wr_addr;
                        got_data[n_wr] = wr_data;
                    end
                    n_wr++;
                    last_acc = i;
                end else begin
                    hold = 1'b1;
                    h_addr = wr_addr;
                    h_data = wr_data;
                end
            end
            if (done_cyc > 0 && i >= done_cyc + 4) break;
            @(negedge clk);
        end
        wr_ready = 1'b0;
        cfg_we = 1'b0;
        start = 1'b0;
        clear_data = m_clear;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NP; i++) begin
            m_kind[i] = 0; m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_data[i] = '0;
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        n_checks++; if (wr_addr !== 9'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 64'd0) begin n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    endtask

    task automatic test_empty();
        int bad, first;
        m_clear = 64'hAA;
        clear_data = m_clear;
        run_pass(100, 0, 0);
        bad = count_bad(n_wr, first);
        n_checks++; if (n_wr !== NV) begin n_fail++; $display("FAIL empty_count got %0d want %0d", n_wr, NV); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL empty_contents got %0d bad (first %0d) want 0", bad, first); end
        n_checks++; if (busy_t1 !== 1) begin n_fail++; $display("FAIL empty_busy_t1 got %0d want 1", busy_t1); end
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL empty_first_valid got %0d want 3", first_valid); end
        n_checks++; if (last_acc !== 514) begin n_fail++; $display("FAIL empty_last_accept got %0d want 514", last_acc); end
        n_checks++; if (done_cyc !== 515) begin n_fail++; $display("FAIL empty_done_cycle got %0d want 515", done_cyc); end
        n_checks++; if (busy_at_done !== 0) begin n_fail++; $display("FAIL empty_busy_at_done got %0d want 0", busy_at_done); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL empty_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_sphere();
        int bad, first, hits;
        logic [DW-1:0] d;
        m_clear = 64'h5555_5555_5555_5555;
        clear_data = m_clear;
        d = {$urandom, $urandom};
        if (d == m_clear) d = ~d;
        cfg_write(0, 1, 4, 4, 4, 2, d);
        for (int i = 1; i < NP; i++) cfg_write(i, 0, 0, 0, 0, 0, {$urandom, $urandom});
        run_pass(100, 0, 0);
        hits = 0;
        for (int k = 0; k < NV; k++) if (got_data[k] === d) hits++;
        bad = count_bad(n_wr, first);
        n_checks++; if (hits !== 33) begin n_fail++; $display("FAIL sphere_hits got %0d want 33", hits); end
        n_checks++; if (got_data[294] !== d) begin n_fail++; $display("FAIL sphere_446 got %h want %h", got_data[294], d); end
        n_checks++; if (got_data[302] !== m_clear) begin n_fail++; $display("FAIL sphere_456 got %h want %h", got_data[302], m_clear); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sphere_contents got %0d bad (first %0d) want 0", bad, first); end
    endtask

    task automatic test_plane_box();
        int bad, first, n0, n1, w0, w1;
        logic [DW-1:0] d0, d1;
        d0 = 64'h0123_4567_89AB_CDEF;
        d1 = 64'hFEDC_BA98_7654_3210;
        m_clear = 64'd0;
        clear_data = m_clear;
        cfg_write(0, 3, $urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(0, 7), d0);
        cfg_write(1, 2, 1, 1, 1, 1, d1);
        cfg_write(2, 0, 0, 0, 0, 0, 64'd0);
        cfg_write(3, 0, 0, 0, 0, 0, 64'd0);
        cfg_write(9, 1, 0, 0, 0, 7, 64'hDEAD);
        run_pass(100, 0, 0);
        n0 = 0; n1 = 0;
        for (int k = 0; k < NV; k++) begin
            if ((k / 8) % 8 == 1) begin
                if (got_data[k] === d0) n0++;
                if (got_data[k] === d1) n1++;
            end
        end
`ifdef VOXEL_GEN_BOX_EN
        w0 = 55; w1 = 9;
`else
        w0 = 64; w1 = 0;
`endif
        bad = count_bad(n_wr, first);
        n_checks++; if (n0 !== w0) begin n_fail++; $display("FAIL plane_slot0 got %0d want %0d", n0, w0); end
        n_checks++; if (n1 !== w1) begin n_fail++; $display("FAIL plane_slot1 got %0d want %0d", n1, w1); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL plane_contents got %0d bad (first %0d) want 0", bad, first); end
    endtask

    task automatic test_backpressure();
        int bad, first;
        random_table();
        run_pass(30, 0, 0);
        bad = count_bad(n_wr, first);
        n_checks++; if (n_wr !== NV) begin n_fail++; $display("FAIL bp_count got %0d want %0d", n_wr, NV); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_contents got %0d bad (first %0d) want 0", bad, first); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d unstable want 0", stab_err); end
        n_checks++; if (done_cyc !== last_acc + 1) begin n_fail++; $display("FAIL bp_done_latency got %0d want %0d", done_cyc, last_acc + 1); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        int bad, first;
        random_table();
        run_pass(100, 100, 0);
        bad = count_bad(n_wr, first);
        n_checks++; if (n_wr !== 100) begin n_fail++; $display("FAIL abort_count got %0d want 100", n_wr); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_contents got %0d bad (first %0d) want 0", bad, first); end
        n_checks++; if (post_abort_valid !== 0) begin n_fail++; $display("FAIL abort_wr_valid got %0d want 0", post_abort_valid); end
        n_checks++; if (post_abort_busy !== 0) begin n_fail++; $display("FAIL abort_busy got %0d want 0", post_abort_busy); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        run_pass(100, 0, 0);
        bad = count_bad(n_wr, first);
        n_checks++; if (n_wr !== NV) begin n_fail++; $display("FAIL restart_count got %0d want %0d", n_wr, NV); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL restart_contents got %0d bad (first %0d) want 0", bad, first); end
        n_checks++; if (done_cyc !== 515) begin n_fail++; $display("FAIL restart_done_cycle got %0d want 515", done_cyc); end
    endtask

    task automatic test_busy_ignore();
        int bad, first;
        random_table();
        run_pass(100, 0, 50);
        bad = count_bad(n_wr, first);
        n_checks++; if (n_wr !== NV) begin n_fail++; $display("FAIL busy_ignore_count got %0d want %0d", n_wr, NV); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL busy_ignore_contents got %0d bad (first %0d) want 0", bad, first); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_ignore_done_pulses got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc !== 515) begin n_fail++; $display("FAIL busy_ignore_done_cycle got %0d want 515", done_cyc); end
        // Slot table must be untouched by the mid-scan write: a second pass reproduces the model
        run_pass(100, 0, 0);
        bad = count_bad(n_wr, first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL busy_ignore_table got %0d bad (first %0d) want 0", bad, first); end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = 4'd0; cfg_kind = 2'd0;
        cfg_cx = 3'd0; cfg_cy = 3'd0; cfg_cz = 3'd0; cfg_r = 3'd0; cfg_data = 64'd0;
        clear_data = 64'd0; start = 1'b0; abort = 1'b0; wr_ready = 1'b0;
        m_clear = 64'd0;
        test_reset();
        test_empty();
        test_sphere();
        test_plane_box();
        test_backpressure();
        test_abort();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
